// File: rtl/color_threshold_filter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : color_filter_pkg
// Description : Mode encoding and threshold defaults shared by the
//               colour threshold filter and its threshold registers.
// Revision    : 1.0 - initial release
// ============================================================================
package color_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BRIGHT    = 2'd0,
        MODE_ALL_ABOVE = 2'd1,
        MODE_KEY       = 2'd2,
        MODE_BYPASS    = 2'd3
    } mode_e;

    localparam int unsigned TH_DEF_DFLT = 600;
    localparam int unsigned TH_MIN_DFLT = 0;
    localparam int unsigned TH_MAX_DFLT = 1020;
    localparam int unsigned STEP_DFLT   = 10;

endpackage
`default_nettype wire

// File: rtl/color_threshold_filter_th_adjust.sv
`default_nettype none
// ============================================================================
// Module      : th_adjust
// Description : One saturating staged threshold plus the active copy that
//               is loaded from it at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module th_adjust
    import color_filter_pkg::*;
#(
    parameter int unsigned CW     = 10,
    parameter int unsigned TH_DEF = TH_DEF_DFLT,
    parameter int unsigned TH_MIN = TH_MIN_DFLT,
    parameter int unsigned TH_MAX = TH_MAX_DFLT,
    parameter int unsigned STEP   = STEP_DFLT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          rst_th_i,
    input  logic          load_i,
    output logic [CW-1:0] staged_o,
    output logic [CW-1:0] active_o
);

    localparam logic [CW:0]   c_STEP_W  = (CW+1)'(STEP);
    localparam logic [CW:0]   c_MAX_W   = (CW+1)'(TH_MAX);
    localparam logic [CW:0]   c_FLOOR_W = (CW+1)'(TH_MIN + STEP);
    localparam logic [CW-1:0] c_STEP_N  = CW'(STEP);
    localparam logic [CW-1:0] c_DEF     = CW'(TH_DEF);
    localparam logic [CW-1:0] c_MIN     = CW'(TH_MIN);
    localparam logic [CW-1:0] c_MAX     = CW'(TH_MAX);

    logic [CW-1:0] staged_q, staged_d;
    logic [CW-1:0] active_q, active_d;
    logic [CW:0]   w_up;
    logic [CW-1:0] w_dn;

    assign w_up = {1'b0, staged_q} + c_STEP_W;
    assign w_dn = staged_q - c_STEP_N;

    // The extra MSB of w_up keeps an overflow past 2^CW visible to the clamp.
    always_comb begin
        staged_d = staged_q;
        if (rst_th_i) begin
            staged_d = c_DEF;
        end else if (inc_i ^ dec_i) begin
            if (inc_i) begin
                staged_d = (w_up > c_MAX_W) ? c_MAX : w_up[CW-1:0];
            end else begin
                staged_d = ({1'b0, staged_q} < c_FLOOR_W) ? c_MIN : w_dn;
            end
        end
    end

    always_comb begin
        active_d = active_q;
        if (load_i) begin
            active_d = staged_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_q <= c_DEF;
            active_q <= c_DEF;
        end else begin
            staged_q <= staged_d;
            active_q <= active_d;
        end
    end

    assign staged_o = staged_q;
    assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/color_threshold_filter.sv
`default_nettype none
// ============================================================================
// Module      : color_threshold_filter
// Description : N-channel pixel binariser with double-buffered runtime
//               thresholds, 2-cycle pipeline and per-frame foreground count.
// Revision    : 1.0 - initial release
// ============================================================================
module color_threshold_filter
    import color_filter_pkg::*;
#(
    parameter int unsigned    CW     = 10,
    parameter int unsigned    NCH    = 3,
    parameter int unsigned    TH_DEF = TH_DEF_DFLT,
    parameter int unsigned    TH_MIN = TH_MIN_DFLT,
    parameter int unsigned    TH_MAX = TH_MAX_DFLT,
    parameter int unsigned    STEP   = STEP_DFLT,
    parameter logic [CW-1:0]  FG_VAL = 'h3FC,
    parameter int unsigned    CNT_W  = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_valid_i,
    input  logic [NCH*CW-1:0]   pix_data_i,
    input  logic                sof_i,
    input  logic [1:0]          mode_i,
    input  logic [1:0]          ch_sel_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                rst_th_i,
    output logic                pix_valid_o,
    output logic [NCH*CW-1:0]   pix_data_o,
    output logic                fg_o,
    output logic [NCH*CW-1:0]   th_o,
    output logic [CNT_W-1:0]    fg_count_o,
    output logic                fg_count_valid_o
);

    localparam int unsigned c_PW = NCH * CW;

    logic              w_load;
    logic [c_PW-1:0]   w_staged;
    logic [c_PW-1:0]   w_active;
    logic [NCH-1:0]    w_ge;
    mode_e             w_mode_eff;
    mode_e             mode_q;

    // Stage 1
    logic              s1_valid_q;
    logic              s1_sof_q;
    logic [NCH-1:0]    s1_ge_q;
    mode_e             s1_mode_q;
    logic [c_PW-1:0]   s1_data_q;

    // Stage 2 / outputs
    logic              valid_q;
    logic [c_PW-1:0]   data_q, data_d;
    logic              fg_q;
    logic              w_class;
    logic              w_fg;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
    logic              cnt_vld_q, cnt_vld_d;

    assign w_load     = sof_i & pix_valid_i;
    assign w_mode_eff = w_load ? mode_e'(mode_i) : mode_q;

    // The sof pixel must see the set it is loading, so bypass the active copy.
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [CW-1:0] w_th_eff;

            th_adjust #(
                .CW     (CW),
                .TH_DEF (TH_DEF),
                .TH_MIN (TH_MIN),
                .TH_MAX (TH_MAX),
                .STEP   (STEP)
            ) u_th (
                .clk      (clk),
                .rst_n    (rst_n),
                .inc_i    (inc_i && (int'(ch_sel_i) == c)),
                .dec_i    (dec_i && (int'(ch_sel_i) == c)),
                .rst_th_i (rst_th_i),
                .load_i   (w_load),
                .staged_o (w_staged[c*CW +: CW]),
                .active_o (w_active[c*CW +: CW])
            );

            assign w_th_eff = w_load ? w_staged[c*CW +: CW] : w_active[c*CW +: CW];
            assign w_ge[c]  = (pix_data_i[c*CW +: CW] >= w_th_eff);
        end
    endgenerate

    always_comb begin
        w_class = 1'b0;
        case (s1_mode_q)
            MODE_BRIGHT:    w_class = |s1_ge_q;
            MODE_ALL_ABOVE: w_class = &s1_ge_q;
            MODE_KEY: begin
                w_class = s1_ge_q[0];
                for (int c = 1; c < int'(NCH); c++) begin
                    w_class = w_class & ~s1_ge_q[c];
                end
            end
            default:        w_class = 1'b0;
        endcase
    end

    assign w_fg = s1_valid_q & w_class;

    always_comb begin
        data_d = '0;
        if (s1_valid_q) begin
            if (s1_mode_q == MODE_BYPASS) begin
                data_d = s1_data_q;
            end else if (w_fg) begin
                data_d = {NCH{FG_VAL}};
            end
        end
    end

    // Frame counter restarts with the sof pixel already included.
    always_comb begin
        cnt_d     = cnt_q;
        cnt_out_d = cnt_out_q;
        cnt_vld_d = 1'b0;
        if (s1_valid_q && s1_sof_q) begin
            cnt_out_d = cnt_q;
            cnt_vld_d = 1'b1;
            cnt_d     = {{(CNT_W-1){1'b0}}, w_fg};
        end else if (w_fg && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_BRIGHT;
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_ge_q    <= '0;
            s1_mode_q  <= MODE_BRIGHT;
            s1_data_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            fg_q       <= 1'b0;
            cnt_q      <= '0;
            cnt_out_q  <= '0;
            cnt_vld_q  <= 1'b0;
        end else begin
            mode_q     <= w_mode_eff;
            s1_valid_q <= pix_valid_i;
            s1_sof_q   <= w_load;
            s1_ge_q    <= w_ge;
            s1_mode_q  <= w_mode_eff;
            s1_data_q  <= pix_valid_i ? pix_data_i : '0;
            valid_q    <= s1_valid_q;
            data_q     <= data_d;
            fg_q       <= w_fg;
            cnt_q      <= cnt_d;
            cnt_out_q  <= cnt_out_d;
            cnt_vld_q  <= cnt_vld_d;
        end
    end

    assign pix_valid_o      = valid_q;
    assign pix_data_o       = data_q;
    assign fg_o             = fg_q;
    assign th_o             = w_staged;
    assign fg_count_o       = cnt_out_q;
    assign fg_count_valid_o = cnt_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_color_threshold_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_threshold_filter
// Description : Self-checking bench for color_threshold_filter against a
//               frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_threshold_filter;

    localparam int CW  = 10;
    localparam int NCH = 3;
    localparam int PW  = CW * NCH;
    localparam logic [PW-1:0] FG_ALL = {10'h3FC, 10'h3FC, 10'h3FC};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pv, sof, inc, dec, rth;
    logic [PW-1:0] pd;
    logic [1:0]    mode, chsel;
    logic          pix_valid_o, fg_o, fg_count_valid_o;
    logic [PW-1:0] pix_data_o, th_o;
    logic [19:0]   fg_count_o;

    color_threshold_filter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pix_valid_i      (pv),
        .pix_data_i       (pd),
        .sof_i            (sof),
        .mode_i           (mode),
        .ch_sel_i         (chsel),
        .inc_i            (inc),
        .dec_i            (dec),
        .rst_th_i         (rth),
        .pix_valid_o      (pix_valid_o),
        .pix_data_o       (pix_data_o),
        .fg_o             (fg_o),
        .th_o             (th_o),
        .fg_count_o       (fg_count_o),
        .fg_count_valid_o (fg_count_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            valid;
        bit            sof;
        bit            fg;
        logic [PW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   m_st[NCH];
    int   m_act[NCH];
    int   m_mode;
    int   m_cnt;
    int   m_cnt_out;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int r, input int g, input int b);
        return {10'(b), 10'(g), 10'(r)};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c]  = 600;
            m_act[c] = 600;
        end
        m_mode    = 0;
        m_cnt     = 0;
        m_cnt_out = 0;
        q.delete();
    endtask

    // Apply the current inputs for one clock and check everything visible afterwards.
    task automatic step();
        exp_t          e;
        int            nge;
        bit            red_ge;
        bit            fg;
        bit            pulse;
        logic [PW-1:0] th_exp;
        e.valid = pv;
        e.sof   = sof && pv;
        e.fg    = 0;
        e.data  = '0;
        if (e.sof) begin
            for (int c = 0; c < NCH; c++) m_act[c] = m_st[c];
            m_mode = int'(mode);
        end
        if (pv) begin
            nge = 0;
            for (int c = 0; c < NCH; c++)
                if (int'(pd[c*CW +: CW]) >= m_act[c]) nge++;
            red_ge = (int'(pd[CW-1:0]) >= m_act[0]);
            case (m_mode)
                0:       fg = (nge > 0);
                1:       fg = (nge == NCH);
                2:       fg = red_ge && (nge == 1);
                default: fg = 0;
            endcase
            e.fg   = fg;
            e.data = (m_mode == 3) ? pd : (fg ? FG_ALL : '0);
        end
        if (rth) begin
            for (int c = 0; c < NCH; c++) m_st[c] = 600;
        end else if ((inc != dec) && (int'(chsel) < NCH)) begin
            if (inc) m_st[chsel] = (m_st[chsel] + 10 > 1020) ? 1020 : m_st[chsel] + 10;
            else     m_st[chsel] = (m_st[chsel] - 10 < 0) ? 0 : m_st[chsel] - 10;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) th_exp[c*CW +: CW] = 10'(m_st[c]);
        chk("th_o", th_o, th_exp);
        if (q.size() >= 2) begin
            e     = q.pop_front();
            pulse = e.valid && e.sof;
            if (pulse) begin
                m_cnt_out = m_cnt;
                m_cnt     = e.fg ? 1 : 0;
            end else if (e.valid && e.fg) begin
                m_cnt++;
            end
            chk("pix_valid_o", pix_valid_o, e.valid);
            chk("pix_data_o", pix_data_o, e.data);
            chk("fg_o", fg_o, e.fg);
            chk("fg_count_valid_o", fg_count_valid_o, pulse);
            chk("fg_count_o", fg_count_o, m_cnt_out);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [PW-1:0] p);
        pv = v; sof = s; pd = p;
        step();
        pv = 0; sof = 0; pd = '0;
    endtask

    task automatic adj(input logic [1:0] ch, input logic i, input logic d, input logic r);
        chsel = ch; inc = i; dec = d; rth = r;
        step();
        inc = 0; dec = 0; rth = 0;
    endtask

    initial begin
        int            flags[100];
        int            tmp, j, pulses, cap, k;
        logic [PW-1:0] p;

        rst_n = 0; pv = 0; sof = 0; pd = '0; mode = 2'd0;
        chsel = 2'd0; inc = 0; dec = 0; rth = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_th_o", th_o, pix(600, 600, 600));
        chk("reset_valid", pix_valid_o, 0);
        chk("reset_count", fg_count_o, 0);
        chk("reset_count_valid", fg_count_valid_o, 0);
        rst_n = 1;

        // BRIGHT: one pixel over on red, one under everywhere
        mode = 2'd0;
        drive(1, 1, pix(700, 100, 100));
        drive(1, 0, pix(500, 500, 500));
        chk("bright_fg", fg_o, 1);
        chk("bright_data", pix_data_o, FG_ALL);
        drive(0, 0, '0);
        chk("bright_bg_fg", fg_o, 0);
        chk("bright_bg_data", pix_data_o, 0);
        drive(0, 0, '0);

        // Threshold saturation on channel 0
        repeat (45) adj(2'd0, 1, 0, 0);
        chk("th_sat_max", th_o[9:0], 1020);
        repeat (110) adj(2'd0, 0, 1, 0);
        chk("th_sat_min", th_o[9:0], 0);
        adj(2'd0, 1, 1, 0);
        chk("th_inc_dec", th_o[9:0], 0);
        adj(2'd3, 1, 0, 0);
        chk("th_bad_sel", th_o, pix(0, 600, 600));
        adj(2'd0, 0, 0, 1);
        chk("th_reset", th_o, pix(600, 600, 600));

        // Mid-frame adjust only lands at the next sof
        mode = 2'd2;
        drive(1, 1, pix(0, 0, 0));
        repeat (10) adj(2'd1, 1, 0, 0);
        chk("th_ch1_700", th_o[19:10], 700);
        drive(1, 0, pix(650, 650, 0));
        drive(0, 0, '0);
        chk("key_before_sof", fg_o, 0);
        drive(1, 1, pix(650, 650, 0));
        drive(0, 0, '0);
        chk("key_after_sof", fg_o, 1);

        // 100-pixel BRIGHT frame with 37 foreground pixels and random bubbles
        adj(2'd0, 0, 0, 1);
        mode = 2'd0;
        for (int i = 0; i < 100; i++) flags[i] = (i < 37) ? 1 : 0;
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = flags[i]; flags[i] = flags[j]; flags[j] = tmp;
        end
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) drive(0, 0, '0);
            if (flags[i] != 0) begin
                p = pix($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
                k = $urandom_range(0, NCH - 1);
                p[k*CW +: CW] = 10'($urandom_range(600, 1023));
            end else begin
                p = pix($urandom_range(0, 599), $urandom_range(0, 599), $urandom_range(0, 599));
            end
            drive(1, (i == 0), p);
        end
        drive(1, 1, pix(10, 10, 10));
        pulses = 0; cap = -1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0);
            if (fg_count_valid_o) begin
                pulses++;
                cap = int'(fg_count_o);
            end
        end
        chk("frame_count_37", cap, 37);
        chk("count_pulse_len", pulses, 1);

        // Asynchronous reset mid-frame
        drive(1, 1, pix(900, 0, 0));
        repeat (3) adj(2'd2, 1, 0, 0);
        drive(1, 0, pix(900, 900, 900));
        rst_n = 0;
        #1;
        chk("arst_valid", pix_valid_o, 0);
        chk("arst_fg", fg_o, 0);
        chk("arst_data", pix_data_o, 0);
        chk("arst_count", fg_count_o, 0);
        chk("arst_th", th_o, pix(600, 600, 600));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        drive(1, 0, pix(800, 0, 0));
        drive(1, 0, pix(100, 100, 100));
        drive(1, 0, pix(0, 700, 0));
        drive(1, 0, pix(0, 0, 650));
        drive(1, 0, pix(599, 599, 599));
        drive(1, 1, pix(0, 0, 0));
        pulses = 0; cap = -1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0);
            if (fg_count_valid_o) begin
                pulses++;
                cap = int'(fg_count_o);
            end
        end
        chk("post_reset_count", cap, 3);
        chk("post_reset_pulse", pulses, 1);

        // Random traffic across all modes and adjust pulses
        for (int i = 0; i < 400; i++) begin
            pv    = ($urandom_range(0, 3) != 0);
            sof   = ($urandom_range(0, 19) == 0);
            mode  = 2'($urandom_range(0, 3));
            chsel = 2'($urandom_range(0, 3));
            inc   = ($urandom_range(0, 3) == 0);
            dec   = ($urandom_range(0, 3) == 0);
            rth   = ($urandom_range(0, 59) == 0);
            pd    = pix($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
            step();
        end
        pv = 0; sof = 0; inc = 0; dec = 0; rth = 0; pd = '0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
